updown_mod_counter: RTL and testbench

UPDOWN_MOD_COUNTER -- requirements
Module: updown_mod_counter

---
 rtl/updown_mod_counter.sv | 65 ++++++
 tb/tb_updown_mod_counter.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/updown_mod_counter.sv
// rtl/updown_mod_counter.sv - up/down modulo counter with wrap or saturate, terminal count and boundary flags
module updown_mod_counter #(
  parameter int unsigned     WIDTH    = 8,
  parameter longint unsigned MODULUS  = 256,
  parameter bit              SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             up,
  output logic [WIDTH-1:0] cnt,
  output logic             tc,
  output logic             bnd,
  output logic             ovf
);

  // MODULUS may equal 2^WIDTH, so the top value is formed in 64 bits before narrowing.
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 64'd1);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  logic             at_top;
  logic             at_bot;
  logic             boundary;
  logic [WIDTH-1:0] cnt_nxt;

  assign at_top   = (cnt == MAX_VAL);
  assign at_bot   = (cnt == '0);
  assign tc       = up ? at_top : at_bot;
  assign boundary = en && !clr && !load && (up ? at_top : at_bot);

  // Next count: clr beats load beats en; boundary steps wrap or hold instead of overflowing.
  always_comb begin
    cnt_nxt = cnt;
    if (clr) begin
      cnt_nxt = '0;
    end else if (load) begin
      cnt_nxt = (load_val > MAX_VAL) ? MAX_VAL : load_val;
    end else if (en) begin
      if (boundary) begin
        if (SATURATE) cnt_nxt = cnt;
        else          cnt_nxt = up ? '0 : MAX_VAL;
      end else begin
        cnt_nxt = up ? (cnt + ONE) : (cnt - ONE);
      end
    end
  end

  // Count, one-cycle boundary pulse and sticky boundary flag; async active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      bnd <= 1'b0;
      ovf <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      bnd <= boundary;
      if (clr)           ovf <= 1'b0;
      else if (boundary) ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_updown_mod_counter.sv
// tb/tb_updown_mod_counter.sv - self-checking bench for updown_mod_counter (three parameter sets)
module tb_updown_mod_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       clr = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_val = 4'd0;
  logic       en = 1'b0;
  logic       up = 1'b0;

  logic [3:0] cnt0, cnt1;
  logic [2:0] cnt2;
  logic       tc0, tc1, tc2, bnd0, bnd1, bnd2, ovf0, ovf1, ovf2;

  int n_cmp = 0;
  int n_err = 0;

  // configs: 0 = (4,10,wrap), 1 = (4,10,saturate), 2 = (3,8,wrap)
  int mod_of [3] = '{10, 10, 8};
  int sat_of [3] = '{0, 1, 0};
  int m_cnt  [3];
  int m_bnd  [3];
  int m_ovf  [3];

  always #5 clk = ~clk;

  updown_mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) dut0 (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val), .en(en), .up(up),
    .cnt(cnt0), .tc(tc0), .bnd(bnd0), .ovf(ovf0));
  updown_mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b1)) dut1 (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val), .en(en), .up(up),
    .cnt(cnt1), .tc(tc1), .bnd(bnd1), .ovf(ovf1));
  updown_mod_counter #(.WIDTH(3), .MODULUS(8), .SATURATE(1'b0)) dut2 (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val[2:0]), .en(en), .up(up),
    .cnt(cnt2), .tc(tc2), .bnd(bnd2), .ovf(ovf2));

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: integer arithmetic straight from the counting rules.
  always @(posedge clk or negedge rst) begin
    int lv, m;
    for (int k = 0; k < 3; k++) begin
      m  = mod_of[k];
      lv = (k == 2) ? (int'(load_val) % 8) : int'(load_val);
      if (!rst) begin
        m_cnt[k] = 0; m_bnd[k] = 0; m_ovf[k] = 0;
      end else if (clr) begin
        m_cnt[k] = 0; m_bnd[k] = 0; m_ovf[k] = 0;
      end else if (load) begin
        m_cnt[k] = (lv < m) ? lv : m - 1;
        m_bnd[k] = 0;
      end else if (en && ((up && m_cnt[k] == m - 1) || (!up && m_cnt[k] == 0))) begin
        m_bnd[k] = 1;
        m_ovf[k] = 1;
        if (sat_of[k] == 0) m_cnt[k] = up ? 0 : m - 1;
      end else begin
        m_bnd[k] = 0;
        if (en) m_cnt[k] = up ? m_cnt[k] + 1 : m_cnt[k] - 1;
      end
    end
  end

  // Every falling edge: all three DUTs against the model.
  always @(negedge clk) begin
    int dc [3];
    int dt [3];
    int db [3];
    int dv [3];
    int et;
    dc = '{int'(cnt0), int'(cnt1), int'(cnt2)};
    dt = '{int'(tc0), int'(tc1), int'(tc2)};
    db = '{int'(bnd0), int'(bnd1), int'(bnd2)};
    dv = '{int'(ovf0), int'(ovf1), int'(ovf2)};
    for (int k = 0; k < 3; k++) begin
      et = (up ? (m_cnt[k] == mod_of[k] - 1) : (m_cnt[k] == 0)) ? 1 : 0;
      chk($sformatf("model cnt%0d", k), dc[k], m_cnt[k]);
      chk($sformatf("model tc%0d", k), dt[k], et);
      chk($sformatf("model bnd%0d", k), db[k], m_bnd[k]);
      chk($sformatf("model ovf%0d", k), dv[k], m_ovf[k]);
    end
  end

  task automatic step(input logic c, input logic l, input logic [3:0] v, input logic e, input logic u);
    clr = c; load = l; load_val = v; en = e; up = u;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_up [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
    int exp_dn [10] = '{8, 7, 6, 5, 4, 3, 2, 1, 0, 9};

    // Reset held: inputs ignored, tc follows up=0.
    step(1'b0, 1'b1, 4'd5, 1'b1, 1'b1);
    step(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
    chk("reset cnt0", cnt0, 0);
    chk("reset ovf0", ovf0, 0);
    up = 1'b0;
    #1;
    chk("reset tc2 up=0", tc2, 1);
    en = 1'b0;
    rst = 1'b1;

    // Down from reset wraps to the top, including MODULUS = 2^WIDTH.
    step(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    chk("down-wrap cnt2", cnt2, 7);
    chk("down-wrap bnd2", bnd2, 1);
    chk("down-wrap ovf2", ovf2, 1);
    chk("down-wrap cnt0", cnt0, 9);
    step(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    chk("clr cnt2", cnt2, 0);
    chk("clr ovf2", ovf2, 0);

    // Up count through the wrap.
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
      chk($sformatf("up seq %0d", i), cnt0, exp_up[i]);
      if (i == 8)  chk("tc0 at 9", tc0, 1);
      if (i == 9)  chk("bnd0 after 9->0", bnd0, 1);
      if (i == 10) chk("bnd0 one cycle", bnd0, 0);
      if (i == 11) chk("ovf0 sticky", ovf0, 1);
    end

    // Saturating instance holds at the top.
    step(1'b1, 1'b0, 4'd0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 4'd8, 1'b0, 1'b1);
    chk("sat load 8", cnt1, 8);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
      chk($sformatf("sat cnt %0d", i), cnt1, 9);
      chk($sformatf("sat bnd %0d", i), bnd1, (i == 0) ? 0 : 1);
    end
    chk("sat ovf", ovf1, 1);

    // Out-of-range load clamps, then count down through the wrap.
    step(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 4'd13, 1'b0, 1'b0);
    chk("load 13 clamps", cnt0, 9);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
      chk($sformatf("down seq %0d", i), cnt0, exp_dn[i]);
      chk($sformatf("down bnd %0d", i), bnd0, (i == 9) ? 1 : 0);
    end

    // clr wins over load and en.
    step(1'b1, 1'b1, 4'd5, 1'b1, 1'b1);
    chk("clr prio cnt", cnt0, 0);
    chk("clr prio ovf", ovf0, 0);
    chk("clr prio bnd", bnd0, 0);

    // Asynchronous reset mid-cycle, then resume.
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
    chk("pre-reset cnt0", cnt0, 6);
    #2;
    rst = 1'b0;
    #1;
    chk("async reset cnt0", cnt0, 0);
    @(posedge clk);
    #1;
    chk("held reset cnt0", cnt0, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("resume cnt0", cnt0, 1);

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
